// File: rtl/memio_hub.sv
// rtl/memio_hub.sv - CPU memory-mapped I/O hub: RAM strobes, read mux and peripheral registers.
// Define MEMIO_TIMER_EN to add the free-running cycle counter at IO offset 6.

module memio_kfifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [W-1:0]               s_tdata,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  output logic [W-1:0]               m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  input  logic                       ovf_clr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          empty, do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign do_pop   = m_tready & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign s_tready = ~full | do_pop;
  assign do_push  = s_tvalid & s_tready;

  assign cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  assign ovf_d = (s_tvalid & ~s_tready) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= s_tdata;
  end

  assign m_tdata  = mem_q[rd_ptr_q];
  assign m_tvalid = ~empty;
  assign count    = cnt_q;
  assign ovf      = ovf_q;
endmodule

module memio_hub #(
  parameter int                  CHAR_W       = 8,
  parameter int                  KFIFO_DEPTH  = 8,
  parameter int                  NCHAN        = 2,
  parameter int                  LIGHTS_W     = 16,
  parameter logic [LIGHTS_W-1:0] LIGHTS_FORCE = 16'hC003,
  parameter int                  BTN_W        = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_wr,
  input  logic                  cpu_rd,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_writedata,
  output logic [31:0]           cpu_readdata,
  output logic                  dmem_wr,
  output logic                  smem_wr,
  input  logic [31:0]           dmem_readdata,
  input  logic [31:0]           smem_readdata,
  input  logic                  keyb_valid,
  input  logic [CHAR_W-1:0]     keyb_char,
  input  logic [31:0]           accel_val,
  input  logic [BTN_W-1:0]      buttons,
  output logic [NCHAN*32-1:0]   period,
  output logic [LIGHTS_W-1:0]   lights
);
  localparam int CW = $clog2(KFIFO_DEPTH) + 1;

  logic [1:0]  region;
  logic [4:0]  off;
  logic        io_sel, wr_io;
  logic        unused_addr_bits;

  assign region  = cpu_addr[17:16];
  assign off     = cpu_addr[6:2];
  assign io_sel  = (region == 2'b11);
  assign wr_io   = cpu_wr & io_sel;
  assign dmem_wr = cpu_wr & (region == 2'b01);
  assign smem_wr = cpu_wr & (region == 2'b10);
  assign unused_addr_bits = ^{cpu_addr[31:18], cpu_addr[15:7], cpu_addr[1:0]};

  logic [CHAR_W-1:0] kf_data;
  logic              kf_valid, kf_pop, kf_ready, kf_full, kf_ovf, kf_ovf_clr;
  logic [CW-1:0]     kf_count;

  assign kf_pop     = cpu_rd & io_sel & (off == 5'd0);
  assign kf_ovf_clr = wr_io & (off == 5'd1) & cpu_writedata[2];

  memio_kfifo #(.W(CHAR_W), .DEPTH(KFIFO_DEPTH)) u_kfifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_tdata  (keyb_char),
    .s_tvalid (keyb_valid),
    .s_tready (kf_ready),
    .m_tdata  (kf_data),
    .m_tvalid (kf_valid),
    .m_tready (kf_pop),
    .ovf_clr  (kf_ovf_clr),
    .count    (kf_count),
    .full     (kf_full),
    .ovf      (kf_ovf)
  );

  logic [LIGHTS_W-1:0] lights_q, lights_d;
  logic [BTN_W-1:0]    btn_q, edge_q, edge_d, edge_clr;
  logic [31:0]         period_q [NCHAN];

  assign lights_d = (wr_io && off == 5'd3) ? cpu_writedata[LIGHTS_W-1:0] : lights_q;
  assign edge_clr = (wr_io && off == 5'd5) ? cpu_writedata[BTN_W-1:0] : '0;
  // New edges are OR'd in after the clear so a coincident set survives.
  assign edge_d   = (edge_q & ~edge_clr) | (buttons & ~btn_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lights_q <= '0;
      btn_q    <= '0;
      edge_q   <= '0;
      for (int c = 0; c < NCHAN; c++) period_q[c] <= '0;
    end else begin
      lights_q <= lights_d;
      btn_q    <= buttons;
      edge_q   <= edge_d;
      for (int c = 0; c < NCHAN; c++) begin
        if (wr_io && off == 5'(8 + c)) period_q[c] <= cpu_writedata;
      end
    end
  end

`ifdef MEMIO_TIMER_EN
  logic [31:0] timer_q, timer_d;

  assign timer_d = (wr_io && off == 5'd6) ? cpu_writedata : timer_q + 32'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) timer_q <= '0;
    else          timer_q <= timer_d;
  end
`endif

  always_comb begin
    for (int c = 0; c < NCHAN; c++) period[c*32 +: 32] = period_q[c];
  end

  assign lights = lights_q | LIGHTS_FORCE;

  logic [31:0] io_rdata, kdata, kstat;
  logic        unused_kf_ready;

  assign unused_kf_ready = kf_ready;

  always_comb begin
    kdata = '0;
    kdata[31] = kf_valid;
    if (kf_valid) kdata[CHAR_W-1:0] = kf_data;

    kstat = '0;
    kstat[15:8] = 8'(kf_count);
    kstat[2] = kf_ovf;
    kstat[1] = kf_full;
    kstat[0] = ~kf_valid;
  end

  always_comb begin
    io_rdata = '0;
    case (off)
      5'd0: io_rdata = kdata;
      5'd1: io_rdata = kstat;
      5'd2: io_rdata = accel_val;
      5'd3: io_rdata = 32'(lights_q);
      5'd4: io_rdata = 32'(buttons);
      5'd5: io_rdata = 32'(edge_q);
`ifdef MEMIO_TIMER_EN
      5'd6: io_rdata = timer_q;
`endif
      default: begin
        for (int c = 0; c < NCHAN; c++) begin
          if (off == 5'(8 + c)) io_rdata = period_q[c];
        end
      end
    endcase
  end

  always_comb begin
    case (region)
      2'b01:   cpu_readdata = dmem_readdata;
      2'b10:   cpu_readdata = smem_readdata;
      2'b11:   cpu_readdata = io_rdata;
      default: cpu_readdata = '0;
    endcase
  end
endmodule

// File: doc/memio_hub.md
Name: memio_hub

Overview:
- Parametrised memory-mapped I/O hub between the single-cycle MIPS CPU and its memories and peripherals.
- Decodes CPU address regions into write strobes for external data and screen RAMs, and muxes read data from them.
- Owns the peripheral register file:
  - keyboard FIFO
  - button edge capture
  - LED register
  - N sound-period channels
- Replaces the fixed single-channel decoder; RAM instances stay outside this block.

Parameters:
- CHAR_W, 8, keyboard character width (1..31).
- KFIFO_DEPTH, 8, keyboard FIFO entries; power of 2, at least 2.
- NCHAN, 2, number of sound-period channels (1..8).
- LIGHTS_W, 16, LED output width (1..32).
- LIGHTS_FORCE, 16'hC003, mask OR'd onto lights; these bits always lit.
- BTN_W, 5, button input width (1..32).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_wr  in  1  CPU store strobe
- cpu_rd  in  1  CPU load strobe; qualifies FIFO pop
- cpu_addr  in  32  byte address; region = [17:16], IO word offset = [6:2]
- cpu_writedata  in  32  store data
- cpu_readdata  out  32  load data, combinational
- dmem_wr  out  1  = cpu_wr & region 2'b01
- smem_wr  out  1  = cpu_wr & region 2'b10
- dmem_readdata  in  32  from data RAM
- smem_readdata  in  32  from screen RAM
- keyb_valid  in  1  one-cycle strobe: new character
- keyb_char  in  CHAR_W  character code
- accel_val  in  32  accelerometer value
- buttons  in  BTN_W  synchronised button levels
- period  out  NCHAN*32  channel c occupies bits [32c+31:32c]
- lights  out  LIGHTS_W  LED drive

Behaviour:
- Read mux:
  - Region 01 returns dmem_readdata.
  - Region 10 returns smem_readdata.
  - Region 00 returns 0.
  - Region 11 returns an IO register per the map below; unmapped offsets read 0 and ignore writes.
- IO map (word offsets):
  - 0 KEYB_DATA (R): {!empty, zeros, head[CHAR_W-1:0]}.
  - 1 KEYB_STAT: reads {count[15:8], zeros, ovf[2], full[1], empty[0]}; writing 1 to bit 2 clears ovf.
  - 2 ACCEL (R): accel_val.
  - 3 LIGHTS (RW): stored reg; lights = reg | LIGHTS_FORCE; readback returns the stored reg only.
  - 4 BUTTONS (R): live levels, zero-extended.
  - 5 BTN_EDGE: sticky rising-edge bits; write-1-to-clear per bit.
  - 8..8+NCHAN-1 PERIOD[c] (RW): full 32 bits.
- Keyboard FIFO:
  - Push on keyb_valid.
  - Pop on rising clk when cpu_rd & region 11 & offset 0 & !empty. The read data is the pre-pop head; the pointer advances at that edge.
  - Push while full and no pop: character dropped, ovf set.
  - Push and pop in the same cycle while full: both happen, count unchanged, ovf unchanged.
  - Pop while empty: no effect; read returns 0.
  - Push while empty with a same-cycle read: read returns 0 (invalid); the entry becomes visible next cycle.
  - Pointers wrap modulo KFIFO_DEPTH; count ranges 0..KFIFO_DEPTH.
- Button edges:
  - Previous-level register btn_q.
  - Edge bit i sets on buttons[i] & !btn_q[i].
  - If a set and a W1C hit the same bit in the same cycle, the set wins.
- Writes to IO registers take effect at the rising edge after the cpu_wr cycle; reads of that register in the same cycle return the old value.
- Reset (async, while reset_n=0):
  - FIFO empty, pointers 0, ovf 0.
  - LIGHTS reg 0, so lights = LIGHTS_FORCE.
  - PERIOD[*] 0, BTN_EDGE 0, btn_q 0.
  - dmem_wr, smem_wr and cpu_readdata stay combinational.
- Reset asserted mid-operation discards FIFO contents; release is synchronous to the next clk edge.

Optional Feature:
- Macro MEMIO_TIMER_EN adds a 32-bit free-running cycle counter at IO offset 6.
  - Counter increments every clk, resets to 0, wraps at 2^32.
  - Any write to offset 6 loads cpu_writedata at that edge.
- Without the macro, offset 6 reads 0, writes are ignored, and no counter logic exists.

Test Plan:
- Reset release: lights = 16'hC003, period = 0, KEYB_STAT reads 32'h0000_0001.
- Push 'A' (8'h41) then 'B'; read offset 0 with cpu_rd twice → 32'h8000_0041 then 32'h8000_0042; third read → 32'h0000_0000.
- Push 9 characters at depth 8 → STAT = {count=8, ovf=1, full=1}; write 4 to STAT → ovf=0, count stays 8.
- Full FIFO with simultaneous push and pop → count stays 8, ovf stays 0, popped value is the oldest entry.
- Store 32'h0000_3FFC to LIGHTS → lights = 16'hFFFF, LIGHTS readback = 32'h0000_3FFC.
- Store PERIOD[1] = 32'h0001_86A0 → period[63:32] matches, period[31:0] stays 0.
- buttons bit 2 rises at the same edge as a W1C of 32'h4 to BTN_EDGE → bit 2 remains 1.
- Store to address 32'h0001_0010 → dmem_wr=1, smem_wr=0.
